regfile_arbiter: RTL and testbench

Controller that shares the single-port 16×4 register file between two requesters and sequences its clearing. It arbitrates read/write requests round-robin, drives the register file's address/data/enable/reset inputs, and returns read data with fixed latency. It also walks all 16 entries to clear them after reset and on command, because the register file's reset only clears the currently addressed, enabled line.

---
 rtl/regfile_arbiter_pkg.sv | 13 +
 rtl/regfile_arbiter_rr_arb2.sv | 19 +
 rtl/regfile_arbiter.sv | 125 ++++++++++++
 tb/tb_regfile_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arbiter_pkg.sv
// Shared types and defaults for the register-file arbiter and its round-robin helper.
package regfile_arbiter_pkg;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned AW_DEF = 4;
  localparam int unsigned DW_DEF = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-way round-robin grant: prio picks the winner only when both requesters are active.
module rr_arb2
  import regfile_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            prio,
  output logic [NREQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req == 2'b11) begin
      gnt[prio] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares a single-port register file between two requesters and walks every entry
// to clear it after reset and on command, since the file's own reset only clears one line.
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_data,
  output logic          rf_en,
  output logic          rf_rst,
  input  logic [DW-1:0] rf_rout
);

  localparam logic [AW-1:0] CNT_MAX = AW'((2 ** AW) - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            prio_q, prio_d;
  logic            rvalid0_q, rvalid1_q;
  logic            rd_issue0, rd_issue1;
  logic [NREQ-1:0] arb_gnt;

  rr_arb2 u_rr_arb2 (
    .req  ({req1, req0}),
    .prio (prio_q),
    .gnt  (arb_gnt)
  );

  // State, clear counter, priority pointer and read-valid flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      prio_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      prio_q    <= prio_d;
      rvalid0_q <= rd_issue0;
      rvalid1_q <= rd_issue1;
    end
  end

  // Next-state and register-file drive
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    prio_d    = prio_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rd_issue0 = 1'b0;
    rd_issue1 = 1'b0;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    rf_addr   = addr0;
    rf_data   = wdata0;
    rf_en     = 1'b0;
    rf_rst    = 1'b0;

    case (state_q)
      CLEAR: begin
        rf_addr   = clr_cnt_q;
        rf_data   = '0;
        rf_en     = 1'b1;
        rf_rst    = 1'b1;
        clr_busy  = 1'b1;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == CNT_MAX) begin
          clr_done  = 1'b1;
          clr_cnt_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        // A clear request pre-empts any pending access for this cycle
        if (clr_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else if (arb_gnt[0]) begin
          gnt0      = 1'b1;
          rf_addr   = addr0;
          rf_data   = wdata0;
          rf_en     = we0;
          rd_issue0 = ~we0;
          prio_d    = 1'b1;
        end else if (arb_gnt[1]) begin
          gnt1      = 1'b1;
          rf_addr   = addr1;
          rf_data   = wdata1;
          rf_en     = we1;
          rd_issue1 = ~we1;
          prio_d    = 1'b0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = rf_rout;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed table, clear/reset sequences and random traffic
// checked against a transaction-level model of the arbiter and register file.
module tb_regfile_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, we0, req1, we1, clr_req;
  logic [3:0] addr0, wdata0, addr1, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, clr_busy, clr_done, rf_en, rf_rst;
  logic [3:0] rdata, rf_addr, rf_data, rf_rout;

  regfile_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .rf_addr(rf_addr), .rf_data(rf_data), .rf_en(rf_en), .rf_rst(rf_rst), .rf_rout(rf_rout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port register file attached to the controller
  logic [3:0] mem [16];
  always @(posedge clk) begin
    rf_rout <= mem[rf_addr];
    if (rf_en) mem[rf_addr] <= rf_rst ? 4'h0 : rf_data;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: clear cycles remaining, last winner, expected contents, pending read data
  int         m_left = 16;
  int         m_last = 1;
  int         m_win  = -1;
  logic [3:0] shadow [16];
  bit         m_rv [2];
  logic [3:0] m_rvd [2];

  task automatic model_check();
    bit e_g0, e_g1, e_busy, e_done, e_en, e_rrst, e_rv0, e_rv1;
    logic [3:0] e_addr, e_data, e_rd;
    bit nrv [2];
    logic [3:0] nrvd [2];
    int w;
    e_g0 = 0; e_g1 = 0; e_busy = 0; e_done = 0; e_en = 0; e_rrst = 0;
    e_rv0 = m_rv[0]; e_rv1 = m_rv[1];
    e_rd = m_rv[0] ? m_rvd[0] : m_rvd[1];
    e_addr = addr0; e_data = wdata0;
    nrv[0] = 0; nrv[1] = 0; nrvd[0] = 4'h0; nrvd[1] = 4'h0;
    m_win = -1;
    if (!rst) begin
      e_rv0 = 0; e_rv1 = 0;
      e_busy = 1; e_en = 1; e_rrst = 1; e_addr = 4'h0; e_data = 4'h0;
      shadow[0] = 4'h0;
      m_left = 16; m_last = 1;
    end else if (m_left > 0) begin
      e_busy = 1; e_en = 1; e_rrst = 1; e_data = 4'h0;
      e_addr = 4'(16 - m_left);
      e_done = (m_left == 1);
      shadow[e_addr] = 4'h0;
      m_left--;
    end else if (clr_req) begin
      m_left = 16;
    end else begin
      w = -1;
      if (req0 && req1) w = 1 - m_last;
      else if (req0) w = 0;
      else if (req1) w = 1;
      if (w >= 0) begin
        m_last = w;
        m_win  = w;
        e_g0 = (w == 0); e_g1 = (w == 1);
        e_addr = (w == 0) ? addr0 : addr1;
        e_data = (w == 0) ? wdata0 : wdata1;
        e_en   = (w == 0) ? we0 : we1;
        if (e_en) shadow[e_addr] = e_data;
        else begin
          nrv[w]  = 1;
          nrvd[w] = shadow[e_addr];
        end
      end
    end
    chk("gnt0", gnt0, e_g0);
    chk("gnt1", gnt1, e_g1);
    chk("rvalid0", rvalid0, e_rv0);
    chk("rvalid1", rvalid1, e_rv1);
    if (e_rv0 || e_rv1) chk("rdata", rdata, e_rd);
    chk("clr_busy", clr_busy, e_busy);
    chk("clr_done", clr_done, e_done);
    chk("rf_en", rf_en, e_en);
    chk("rf_rst", rf_rst, e_rrst);
    chk("rf_addr", rf_addr, e_addr);
    chk("rf_data", rf_data, e_data);
    m_rv = nrv;
    m_rvd = nrvd;
  endtask

  task automatic half();
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    half();
    adv();
  endtask

  typedef struct {
    logic       req0, we0;
    logic [3:0] addr0, wdata0;
    logic       req1, we1;
    logic [3:0] addr1, wdata1;
    logic       g0, g1, rv0, rv1;
    logic [3:0] rd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 4'h5, 4'hA, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[1] = '{1'b1, 1'b0, 4'h5, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[2] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hA};
    tbl[3] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h3, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
    tbl[4] = '{1'b1, 1'b0, 4'h5, 4'h0, 1'b1, 1'b0, 4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[5] = '{1'b1, 1'b0, 4'h5, 4'h0, 1'b1, 1'b0, 4'h3, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hA};
    tbl[6] = '{1'b1, 1'b0, 4'h5, 4'h0, 1'b1, 1'b0, 4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h6};
    tbl[7] = '{1'b1, 1'b0, 4'h5, 4'h0, 1'b1, 1'b0, 4'h3, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hA};
    tbl[8] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h6};
    tbl[9] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};

    rst = 1'b0; clr_req = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'h0; wdata0 = 4'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 4'h0; wdata1 = 4'h0;

    // Reset state, with a request held to show it is not granted
    half();
    chk("rst_busy", clr_busy, 1'b1);
    chk("rst_rf_en", rf_en, 1'b1);
    chk("rst_rf_rst", rf_rst, 1'b1);
    chk("rst_gnt0", gnt0, 1'b0);
    adv();
    cycle();
    rst = 1'b1;

    // Post-reset walk over all 16 entries, first grant in cycle 16
    for (int i = 0; i < 16; i++) begin
      half();
      chk("walk_addr", rf_addr, 8'(i));
      chk("walk_busy", clr_busy, 1'b1);
      chk("walk_done", clr_done, (i == 15) ? 1'b1 : 1'b0);
      chk("walk_gnt0", gnt0, 1'b0);
      adv();
    end
    half();
    chk("first_gnt", gnt0, 1'b1);
    adv();
    req0 = 1'b0;
    cycle();

    // Directed table: write/read turnaround, then contention
    for (int i = 0; i < 10; i++) begin
      req0 = tbl[i].req0; we0 = tbl[i].we0; addr0 = tbl[i].addr0; wdata0 = tbl[i].wdata0;
      req1 = tbl[i].req1; we1 = tbl[i].we1; addr1 = tbl[i].addr1; wdata1 = tbl[i].wdata1;
      half();
      chk("tbl_gnt0", gnt0, tbl[i].g0);
      chk("tbl_gnt1", gnt1, tbl[i].g1);
      chk("tbl_rvalid0", rvalid0, tbl[i].rv0);
      chk("tbl_rvalid1", rvalid1, tbl[i].rv1);
      if (tbl[i].rv0 || tbl[i].rv1) chk("tbl_rdata", rdata, tbl[i].rd);
      adv();
    end

    // Clear command with requester 1 pending
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'hA; wdata0 = 4'hF;
    half();
    chk("cw_gnt0", gnt0, 1'b1);
    adv();
    req0 = 1'b0; clr_req = 1'b1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'hA;
    half();
    chk("clr_accept_gnt1", gnt1, 1'b0);
    chk("clr_accept_en", rf_en, 1'b0);
    adv();
    clr_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      half();
      chk("cmd_busy", clr_busy, 1'b1);
      chk("cmd_gnt1", gnt1, 1'b0);
      chk("cmd_done", clr_done, (i == 15) ? 1'b1 : 1'b0);
      adv();
    end
    half();
    chk("post_clr_gnt1", gnt1, 1'b1);
    adv();
    req1 = 1'b0;
    half();
    chk("post_clr_rvalid1", rvalid1, 1'b1);
    chk("post_clr_rdata", rdata, 4'h0);
    adv();

    // Reset asserted when the walk reaches entry 7
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    for (int i = 0; i < 7; i++) cycle();
    rst = 1'b0;
    half();
    chk("midclr_addr", rf_addr, 4'h0);
    chk("midclr_busy", clr_busy, 1'b1);
    adv();
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      half();
      chk("rewalk_addr", rf_addr, 8'(i));
      adv();
    end
    half();
    chk("rewalk_end", clr_busy, 1'b0);
    adv();

    // Reset the cycle after a read grant drops the response
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'h3;
    half();
    chk("rd_gnt1", gnt1, 1'b1);
    adv();
    req1 = 1'b0; rst = 1'b0;
    half();
    chk("rd_rst_rvalid1", rvalid1, 1'b0);
    adv();
    rst = 1'b1;
    for (int i = 0; i < 17; i++) cycle();

    // Random traffic against the model
    for (int n = 0; n < 2500; n++) begin
      if (m_win == 0 || !req0) begin
        req0 = ($urandom_range(0, 3) != 0); we0 = 1'($urandom);
        addr0 = 4'($urandom); wdata0 = 4'($urandom);
      end
      if (m_win == 1 || !req1) begin
        req1 = ($urandom_range(0, 3) != 0); we1 = 1'($urandom);
        addr1 = 4'($urandom); wdata1 = 4'($urandom);
      end
      clr_req = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 399) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
